// File: rtl/fb_reader_if.sv
// Framebuffer read port and pixel stream between fb_reader (master) and its
// environment (slave): memory request/grant/data plus valid/ready pixel output.
interface fb_reader_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sol;
  logic              pix_sof;

  modport master (
    output mem_req, mem_addr, pix_data, pix_valid, pix_sol, pix_sof,
    input  mem_gnt, mem_rdata, pix_ready
  );

  modport slave (
    input  mem_req, mem_addr, pix_data, pix_valid, pix_sol, pix_sof,
    output mem_gnt, mem_rdata, pix_ready
  );
endinterface

// File: rtl/fb_reader.sv
// Frame-buffer scan-out: raster-order reads with a waterfall row offset,
// streamed through a 2-entry buffer that absorbs read latency and back-pressure.
module fb_reader #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  row_offset,
  output logic        busy,
  output logic        frame_done,
  fb_reader_if.master bus
);
  localparam int COL_W = $clog2(H_RES);
  localparam int ROW_W = $clog2(V_RES);
  localparam logic [ADDR_W-1:0] LINE_SZ  = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(H_RES * V_RES);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   y;
  logic [ADDR_W-1:0]  line_base, line_base_inc;
  logic [7:0]         ro_eff;
  logic               req, issue, pop, push, accept, done, last_pix, credit_ok;
  logic [2:0]         pending;

  logic               rd_vld_p1, rd_sol_p1, rd_sof_p1;

  logic [1:0]         occ;
  logic [DATA_W-1:0]  head_data, tail_data;
  logic               head_sol, head_sof, tail_sol, tail_sof;

  assign ro_eff        = (int'(row_offset) >= V_RES) ? 8'd0 : row_offset;
  assign line_base_inc = line_base + LINE_SZ;
  assign accept        = (state == IDLE) && start;
  assign issue         = req && bus.mem_gnt;
  assign push          = rd_vld_p1;
  assign pop           = (occ != 2'd0) && bus.pix_ready;
  assign last_pix      = (col == COL_LAST) && (y == ROW_LAST);

  // Credit counts a pop in this cycle as already freed, so one read per clock
  // sustains while the buffer plus the in-flight read never exceed two.
  assign pending   = {1'b0, occ} + {2'b00, rd_vld_p1} - {2'b00, pop};
  assign credit_ok = pending < 3'd2;
  assign done      = (state == DRAIN) && pop && (occ == 2'd1) && !rd_vld_p1;

  assign busy          = (state != IDLE);
  assign bus.mem_req   = req;
  assign bus.mem_addr  = line_base + ADDR_W'(col);
  assign bus.pix_valid = (occ != 2'd0);
  assign bus.pix_data  = head_data;
  assign bus.pix_sol   = head_sol && bus.pix_valid;
  assign bus.pix_sof   = head_sof && bus.pix_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: begin
        req = credit_ok;
        if (req && bus.mem_gnt && last_pix) state_nxt = DRAIN;
      end
      DRAIN: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address generation: raster walk with per-line base and frame wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col       <= '0;
      y         <= '0;
      line_base <= '0;
    end else if (accept) begin
      col       <= '0;
      y         <= '0;
      line_base <= ADDR_W'(ro_eff) * LINE_SZ;
    end else if (issue) begin
      if (col == COL_LAST) begin
        col       <= '0;
        y         <= y + ROW_W'(1);
        line_base <= (line_base_inc == FRAME_SZ) ? '0 : line_base_inc;
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Read issued -> data returns next cycle with its line/frame tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_p1  <= 1'b0;
      rd_sol_p1  <= 1'b0;
      rd_sof_p1  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rd_vld_p1  <= issue;
      rd_sol_p1  <= issue && (col == '0);
      rd_sof_p1  <= issue && (col == '0) && (y == '0);
      frame_done <= done;
    end
  end

  // Output buffer: head register drives the stream, tail holds a second entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ       <= 2'd0;
      head_data <= '0;
      head_sol  <= 1'b0;
      head_sof  <= 1'b0;
      tail_data <= '0;
      tail_sol  <= 1'b0;
      tail_sof  <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head_data <= bus.mem_rdata;
            head_sol  <= rd_sol_p1;
            head_sof  <= rd_sof_p1;
          end else begin
            tail_data <= bus.mem_rdata;
            tail_sol  <= rd_sol_p1;
            tail_sof  <= rd_sof_p1;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_sol  <= tail_sol;
          head_sof  <= tail_sof;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_data <= bus.mem_rdata;
            head_sol  <= rd_sol_p1;
            head_sof  <= rd_sof_p1;
          end else begin
            head_data <= tail_data;
            head_sol  <= tail_sol;
            head_sof  <= tail_sof;
            tail_data <= bus.mem_rdata;
            tail_sol  <= rd_sol_p1;
            tail_sof  <= rd_sof_p1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
